instr_prefetch_queue: RTL and testbench

//  Instruction fetch stage directly upstream of the single-cycle datapath: fetches 32-bit words

---
 rtl/prefetch_pkg.sv | 22 ++
 rtl/prefetch_fifo.sv | 69 ++++++
 rtl/instr_prefetch_queue.sv | 137 +++++++++++++
 tb/tb_instr_prefetch_queue.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prefetch_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package prefetch_pkg;

    localparam int          INSTR_W = 32;
    localparam logic [31:0] PC_INC  = 32'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [INSTR_W-1:0] pc;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Circular buffer of fetched {instr, pc} entries with flush; head read straight from storage.
module prefetch_fifo
    import prefetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    output fetch_entry_t head,
    output logic         empty,
    output logic [CNT_W-1:0] count
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;
    fetch_entry_t     mem_q [DEPTH];

    // Overrun is impossible: the fetch FSM reserves a slot before each request.
    always_comb begin
        do_push  = push && !flush;
        do_pop   = pop && (count_q != '0) && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= push_entry;
    end

    assign head  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch stage: req/ack fetch FSM feeding a small queue toward the datapath.
// Optional PREFETCH_BYPASS_EN: an accepted ack into an empty queue is presented the same cycle.
module instr_prefetch_queue
    import prefetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_t     state_q, state_d;
    logic             mem_req_q, mem_req_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic             accept;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    fetch_entry_t     fifo_head;
    fetch_entry_t     new_entry;

    assign accept    = (state_q == WAIT) && mem_ack && !redirect;
    assign new_entry = '{instr: mem_rdata, pc: fetch_pc_q};

    // A redirect with an outstanding request must still wait out the ack (DRAIN).
    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        fetch_pc_d = fetch_pc_q;
        if (redirect) begin
            fetch_pc_d = word_align(redirect_pc);
            case (state_q)
                WAIT, DRAIN: begin
                    if (mem_ack) begin
                        mem_req_d = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        state_d   = DRAIN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else begin
            case (state_q)
                IDLE: begin
                    if (fifo_count < CNT_W'(DEPTH)) begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = fetch_pc_q;
                        state_d    = WAIT;
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        fetch_pc_d = fetch_pc_q + PC_INC;
                        mem_req_d  = 1'b0;
                        state_d    = IDLE;
                    end
                end
                DRAIN: begin
                    if (mem_ack) begin
                        mem_req_d = 1'b0;
                        state_d   = IDLE;
                    end
                end
                default: begin
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= word_align(RESET_PC);
            fetch_pc_q <= word_align(RESET_PC);
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;

    // Flush takes priority inside the FIFO, so a pop during redirect is ignored.
    assign fifo_pop = instr_ready && !redirect;

`ifdef PREFETCH_BYPASS_EN
    logic bypass_hit;
    assign bypass_hit  = fifo_empty && accept;
    assign instr_valid = !fifo_empty || bypass_hit;
    assign instr       = fifo_empty ? mem_rdata  : fifo_head.instr;
    assign instr_pc    = fifo_empty ? fetch_pc_q : fifo_head.pc;
    assign fifo_push   = accept && !(bypass_hit && instr_ready);
`else
    assign instr_valid = !fifo_empty;
    assign instr       = fifo_head.instr;
    assign instr_pc    = fifo_head.pc;
    assign fifo_push   = accept;
`endif

    prefetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .flush      (redirect),
        .push       (fifo_push),
        .push_entry (new_entry),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Bench for instr_prefetch_queue: directed scenarios plus randomized traffic against a stream model.
module tb_instr_prefetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    instr_prefetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    int          checks = 0;
    int          errors = 0;
    ent_t        q[$];
    logic [31:0] req_log[$];
    logic        busy;
    logic        orphan;
    logic [31:0] exp_fetch;
    logic [31:0] req_addr;

    // Instruction memory contents: address 0 holds 0xDEADBEEF.
    function automatic logic [31:0] memword(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        mem_ack     = 1'b0;
        mem_rdata   = 32'h0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        #1;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_mem_addr", mem_addr, RESET_PC);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        q.delete();
        req_log.delete();
        busy      = 1'b0;
        orphan    = 1'b0;
        exp_fetch = RESET_PC;
        req_addr  = RESET_PC;
    endtask

    // One clock cycle, entered and left at a falling edge. Memory answers with ack only
    // while a request is up; the model tracks the expected instruction stream.
    task automatic step(input logic ack, input logic rdy, input logic rd, input logic [31:0] rpc);
        logic acc;
        logic hv;
        logic byp;
        ent_t e;
        if (busy) begin
            check("req_hold", 32'(mem_req), 32'd1);
            check("addr_hold", mem_addr, req_addr);
        end else if (mem_req) begin
            busy     = 1'b1;
            req_addr = mem_addr;
            req_log.push_back(mem_addr);
            check("req_addr", mem_addr, exp_fetch);
        end
        mem_ack     = ack && mem_req;
        mem_rdata   = mem_ack ? memword(req_addr) : $urandom;
        instr_ready = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        acc = mem_ack && !orphan && !rd;
        #1;
        byp = 1'b0;
`ifdef PREFETCH_BYPASS_EN
        hv  = (q.size() != 0) || acc;
        byp = (q.size() == 0) && acc;
`else
        hv  = (q.size() != 0);
`endif
        check("instr_valid", 32'(instr_valid), 32'(hv));
        if (hv) begin
            if (byp) begin
                e.instr = memword(req_addr);
                e.pc    = req_addr;
            end else begin
                e = q[0];
            end
            check("instr", instr, e.instr);
            check("instr_pc", instr_pc, e.pc);
        end
        if (rd) begin
            q.delete();
            exp_fetch = {rpc[31:2], 2'b00};
            if (mem_ack) begin
                busy   = 1'b0;
                orphan = 1'b0;
            end else if (busy) begin
                orphan = 1'b1;
            end
        end else begin
            if (hv && rdy && !byp) void'(q.pop_front());
            if (mem_ack) begin
                busy = 1'b0;
                if (!orphan) begin
                    exp_fetch = exp_fetch + 32'd4;
                    if (!(byp && rdy)) begin
                        e.instr = memword(req_addr);
                        e.pc    = req_addr;
                        q.push_back(e);
                    end
                end
                orphan = 1'b0;
            end
        end
        check("no_overrun", 32'(q.size() <= DEPTH), 32'd1);
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        // Streaming fetch with immediate acks and an always-ready consumer.
        do_reset();
        step(mem_req, 1'b1, 1'b0, 32'h0);
        step(mem_req, 1'b1, 1'b0, 32'h0);
`ifndef PREFETCH_BYPASS_EN
        check("t1_first_valid", 32'(instr_valid), 32'd1);
        check("t1_first_pc", instr_pc, 32'h0);
`endif
        for (int i = 0; i < 7; i++) step(mem_req, 1'b1, 1'b0, 32'h0);
        check("t1_nreq_ge4", 32'(req_log.size() >= 4), 32'd1);
        for (int k = 0; k < 4; k++) check("t1_addr_seq", req_log[k], 32'(4 * k));

        // Stalled consumer: queue fills after exactly DEPTH fetches.
        do_reset();
        for (int i = 0; i < 20; i++) step(mem_req, 1'b0, 1'b0, 32'h0);
        check("t2_nreq", 32'(req_log.size()), 32'(DEPTH));
        check("t2_req_idle", 32'(mem_req), 32'd0);
        check("t2_valid", 32'(instr_valid), 32'd1);
        check("t2_head_pc", instr_pc, 32'h0);

        // Redirect during WAIT; the late ack is drained and dropped.
        do_reset();
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("t3_wait_req", 32'(mem_req), 32'd1);
        step(1'b0, 1'b1, 1'b1, 32'h40);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check("t3_valid", 32'(instr_valid), 32'd0);
        check("t3_req_low", 32'(mem_req), 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("t3_req", 32'(mem_req), 32'd1);
        check("t3_addr", mem_addr, 32'h40);

        // Redirect in the same cycle as the ack: no DRAIN.
        do_reset();
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h80);
        check("t4_req_low", 32'(mem_req), 32'd0);
        check("t4_valid", 32'(instr_valid), 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("t4_req", 32'(mem_req), 32'd1);
        check("t4_addr", mem_addr, 32'h80);

        // Unaligned redirect target is word aligned.
        do_reset();
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'h43);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("t5_addr", mem_addr, 32'h40);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("t5_valid", 32'(instr_valid), 32'd1);
        check("t5_pc", instr_pc, 32'h40);

        // Asynchronous reset in the middle of a WAIT with a queued word.
        do_reset();
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("t6_pre_req", 32'(mem_req), 32'd1);
        check("t6_pre_valid", 32'(instr_valid), 32'd1);
        #2;
        do_reset();
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("t6_restart_req", 32'(mem_req), 32'd1);
        check("t6_restart_addr", mem_addr, RESET_PC);

        // Randomized traffic, including redirects near the top of the address space.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic        a;
            logic        r;
            logic        d;
            logic [31:0] p;
            a = mem_req && ($urandom_range(0, 2) == 0);
            r = ((i % 200) < 60) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            d = ($urandom_range(0, 19) == 0);
            p = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            step(a, r, d, p);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
